// File: rtl/fsm.sv
// Serial detector for the 12-bit codeword 1011_1111_1111 (first bit first) on lfsr_out.
// Define FSM_OVERLAP_EN to let the trailing 1 of a detected codeword start the next match.
module fsm (
   input  logic clk,
   input  logic rst_n,
   input  logic lfsr_out,
   output logic seq_detect
);

   localparam logic [3:0] S0  = 4'd0;
   localparam logic [3:0] S1  = 4'd1;
   localparam logic [3:0] S2  = 4'd2;
   localparam logic [3:0] S3  = 4'd3;
   localparam logic [3:0] S4  = 4'd4;
   localparam logic [3:0] S5  = 4'd5;
   localparam logic [3:0] S6  = 4'd6;
   localparam logic [3:0] S7  = 4'd7;
   localparam logic [3:0] S8  = 4'd8;
   localparam logic [3:0] S9  = 4'd9;
   localparam logic [3:0] S10 = 4'd10;
   localparam logic [3:0] S11 = 4'd11;
   localparam logic [3:0] S12 = 4'd12;

   logic [3:0] state_reg;
   logic [3:0] state_next;
   logic       seq_detect_reg;

   // Sk: the last k bits equal the first k codeword bits; a 0 after "1011..." falls back to "10".
   always_comb begin
      state_next = S0;
      case (state_reg)
         S0:  state_next = lfsr_out ? S1 : S0;
         S1:  state_next = lfsr_out ? S1 : S2;
         S2:  state_next = lfsr_out ? S3 : S0;
         S3, S4, S5, S6, S7, S8, S9, S10, S11:
              state_next = lfsr_out ? (state_reg + 4'd1) : S2;
`ifdef FSM_OVERLAP_EN
         S12: state_next = lfsr_out ? S1 : S2;
`else
         S12: state_next = lfsr_out ? S1 : S0;
`endif
         default: state_next = S0;
      endcase
   end

   // The flag is registered from the next state so it is high exactly while state_reg is S12.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         state_reg      <= S0;
         seq_detect_reg <= 1'b0;
      end else begin
         state_reg      <= state_next;
         seq_detect_reg <= (state_next == S12);
      end
   end

   assign seq_detect = seq_detect_reg;

endmodule

// File: tb/tb_fsm.sv
// Self-checking bench for fsm: a history-based longest-prefix model pushes expected states
// into a queue as each bit is driven; they are popped and compared after the sampling edge.
module tb_fsm;

   logic clk;
   logic rst_n;
   logic lfsr_out;
   logic seq_detect;

   int checks = 0;
   int errors = 0;

   localparam logic [11:0] CODEWORD = 12'b1011_1111_1111;

`ifdef FSM_OVERLAP_EN
   localparam bit OVERLAP = 1'b1;
`else
   localparam bit OVERLAP = 1'b0;
`endif

   logic [3:0]  exp_q[$];
   logic [15:0] hist;
   int          hlen;
   int          pulses;

   fsm dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .lfsr_out   (lfsr_out),
      .seq_detect (seq_detect)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [3:0] match_len(input logic [15:0] h, input int len);
      logic [11:0] pre;
      logic [11:0] suf;
      for (int k = 12; k >= 1; k--) begin
         if (k <= len) begin
            pre = CODEWORD >> (12 - k);
            suf = h[11:0] & ((12'd1 << k) - 12'd1);
            if (k == 12) suf = h[11:0];
            if (suf == pre) return 4'(k);
         end
      end
      return 4'd0;
   endfunction

   task automatic pop_and_check(input string name);
      logic [3:0] exp_s;
      logic       exp_d;
      exp_s = exp_q.pop_front();
      exp_d = (exp_s == 4'd12);
      checks++;
      if (seq_detect !== exp_d) begin
         errors++;
         $display("FAIL %s seq_detect got %b expected %b", name, seq_detect, exp_d);
      end
      checks++;
      if (dut.state_reg !== exp_s) begin
         errors++;
         $display("FAIL %s state got %0d expected %0d", name, dut.state_reg, exp_s);
      end
      if (seq_detect === 1'b1) pulses++;
   endtask

   task automatic reset_cycle(input string name);
      @(negedge clk);
      rst_n    = 1'b1;
      lfsr_out = 1'b1;
      hist     = '0;
      hlen     = 0;
      exp_q.push_back(4'd0);
      @(posedge clk);
      #1;
      pop_and_check(name);
   endtask

   task automatic drive_bit(input logic b, input string name);
      logic [3:0] s;
      @(negedge clk);
      rst_n    = 1'b0;
      lfsr_out = b;
      hist     = {hist[14:0], b};
      if (hlen < 16) hlen++;
      s = match_len(hist, hlen);
      if (s == 4'd12 && !OVERLAP) hlen = 0;
      exp_q.push_back(s);
      @(posedge clk);
      #1;
      pop_and_check(name);
   endtask

   task automatic drive_bits(input logic [31:0] bits, input int n, input string name);
      for (int i = n - 1; i >= 0; i--) drive_bit(bits[i], name);
   endtask

   task automatic expect_pulses(input int want, input string name);
      checks++;
      if (pulses != want) begin
         errors++;
         $display("FAIL %s pulse count got %0d expected %0d", name, pulses, want);
      end
   endtask

   task automatic test_reset;
      for (int i = 0; i < 5; i++) reset_cycle("reset_hold");
   endtask

   task automatic test_codeword;
      reset_cycle("codeword_rst");
      pulses = 0;
      drive_bits(32'h0BFF, 12, "codeword");
      drive_bits(32'h0, 2, "codeword_tail");
      expect_pulses(1, "codeword");
   endtask

   task automatic test_near_miss;
      reset_cycle("near_miss_rst");
      pulses = 0;
      drive_bits(32'b1011_1111_1110, 12, "near_miss");
      expect_pulses(0, "near_miss");
      checks++;
      if (dut.state_reg !== 4'd2) begin
         errors++;
         $display("FAIL near_miss_final state got %0d expected 2", dut.state_reg);
      end
   endtask

   task automatic test_prefix_fallback;
      reset_cycle("fallback_rst");
      pulses = 0;
      drive_bits(32'b1101_0111_1111_1111, 16, "fallback");
      expect_pulses(1, "fallback");
   endtask

   task automatic test_back_to_back;
      reset_cycle("b2b_rst");
      pulses = 0;
      drive_bits(32'h0BFF, 12, "b2b_first");
      drive_bits(32'b011_1111_1111, 11, "b2b_second");
      drive_bit(1'b0, "b2b_tail");
      expect_pulses(OVERLAP ? 2 : 1, "b2b");
   endtask

   task automatic test_reset_mid;
      reset_cycle("mid_rst0");
      pulses = 0;
      drive_bits(32'b1011_1111, 8, "mid_pre");
      reset_cycle("mid_rst");
      drive_bits(32'b1111, 4, "mid_post");
      expect_pulses(0, "reset_mid");
   endtask

   task automatic test_random;
      reset_cycle("random_rst");
      for (int i = 0; i < 400; i++) begin
         if ((i % 40) < 14) drive_bit(((i % 40) == 1) ? 1'b0 : 1'b1, "random_cw");
         else drive_bit(1'($urandom_range(0, 1)), "random");
      end
   endtask

   initial begin
      rst_n    = 1'b1;
      lfsr_out = 1'b0;
      hist     = '0;
      hlen     = 0;
      pulses   = 0;
      test_reset();
      test_codeword();
      test_near_miss();
      test_prefix_fallback();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
